// File: rtl/rot_sq_pkg.sv
// rot_sq_pkg: segment patterns, control modes and position decode shared by the
// rotating-square sequencer.
package rot_sq_pkg;

    localparam logic [7:0] SSEG_UPPER = 8'h9C;
    localparam logic [7:0] SSEG_LOWER = 8'hA3;
    localparam logic [7:0] SSEG_BLANK = 8'hFF;

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } ctrl_t;

    typedef struct packed {
        logic [31:0] digit;
        logic        lower;
    } pos_dec_t;

    // Upper squares sweep left-to-right, then lower squares sweep right-to-left.
    function automatic pos_dec_t decode_pos(input int p, input int n);
        pos_dec_t d;
        d.lower = (p >= n);
        d.digit = d.lower ? 32'(p - n) : 32'(n - 1 - p);
        return d;
    endfunction

endpackage

// File: rtl/rot_tick_gen.sv
// rot_tick_gen: mod-TICK_DIV divider that holds its count while run is low and
// flags the terminal-count cycle.
module rot_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    always_comb tick = run && (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (run)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/rotating_square_sequencer.sv
// rotating_square_sequencer: drives a square around N seven-segment digits, with
// a built-in step-rate divider, pause/single-step and lap/step status pulses.
module rotating_square_sequencer
    import rot_sq_pkg::*;
#(
    parameter  int N_DIGITS = 4,
    parameter  int TICK_DIV = 25_000_000,
    localparam int POS_W    = $clog2(2 * N_DIGITS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                cw,
    input  logic                step,
    output logic [N_DIGITS-1:0] an,
    output logic [7:0]          sseg,
    output logic [POS_W-1:0]    pos,
    output logic                step_pulse,
    output logic                lap
);

    localparam logic [POS_W-1:0] LAST = POS_W'(2 * N_DIGITS - 1);

    ctrl_t               mode;
    logic                tick;
    logic                advance;
    logic                wrap;
    logic [POS_W-1:0]    next_pos;
    pos_dec_t            dec;
    logic [N_DIGITS-1:0] next_an;
    logic [7:0]          next_sseg;

    rot_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .run  (mode == RUN),
        .tick (tick)
    );

    // en has priority: a step request only counts while paused.
    always_comb begin
        mode      = en ? RUN : PAUSE;
        advance   = (mode == RUN) ? tick : step;
        wrap      = cw ? (pos == LAST) : (pos == '0);
        next_pos  = cw ? (wrap ? '0 : pos + 1'b1) : (wrap ? LAST : pos - 1'b1);
        dec       = decode_pos(32'(next_pos), N_DIGITS);
        next_an   = ~(N_DIGITS'(1) << dec.digit);
        next_sseg = dec.lower ? SSEG_LOWER : SSEG_UPPER;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos        <= '0;
            an         <= ~(N_DIGITS'(1) << (N_DIGITS - 1));
            sseg       <= SSEG_UPPER;
            step_pulse <= 1'b0;
            lap        <= 1'b0;
        end else begin
            step_pulse <= advance;
            lap        <= advance && wrap;
            if (advance) begin
                pos  <= next_pos;
                an   <= next_an;
                sseg <= next_sseg;
            end
        end
    end

endmodule

// File: tb/tb_rotating_square_sequencer.sv
// tb_rotating_square_sequencer: directed checks of the rotating-square sequencer
// with N_DIGITS=4, TICK_DIV=4.
module tb_rotating_square_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       cw = 1'b1;
    logic       step = 1'b0;
    logic [3:0] an;
    logic [7:0] sseg;
    logic [2:0] pos;
    logic       step_pulse;
    logic       lap;

    int tests = 0;
    int fails = 0;
    int laps  = 0;

    logic [3:0] an_tab [8] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110,
                               4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    rotating_square_sequencer #(.N_DIGITS(4), .TICK_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cw        (cw),
        .step      (step),
        .an        (an),
        .sseg      (sseg),
        .pos       (pos),
        .step_pulse(step_pulse),
        .lap       (lap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic state(input string tag, input int p, input logic sp, input logic lp);
        chk({tag, ".pos"}, 32'(pos), 32'(p));
        chk({tag, ".an"}, 32'(an), 32'(an_tab[p]));
        chk({tag, ".sseg"}, 32'(sseg), (p < 4) ? 32'h9C : 32'hA3);
        chk({tag, ".step_pulse"}, 32'(step_pulse), 32'(sp));
        chk({tag, ".lap"}, 32'(lap), 32'(lp));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // asynchronous reset before any clock edge
        #3 reset = 1'b1;
        #1 state("reset", 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;
        cw    = 1'b1;
        // free run clockwise: one advance per 4 cycles
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            state($sformatf("run%0d", i), (i / 4) % 8, (i % 4) == 0, i == 32);
            if (lap) laps++;
        end
        chk("lap_count", 32'(laps), 32'd1);
        // counter-clockwise wrap 0 -> 7
        cw = 1'b0;
        cyc(4); state("ccw_to0", 0, 1'b1, 1'b0);
        cyc(4); state("ccw_wrap", 7, 1'b1, 1'b1);
        cyc(1); state("ccw_hold", 7, 1'b0, 1'b0);
        cyc(3); state("ccw_to6", 6, 1'b1, 1'b0);
        // cw sampled only in the advance cycle
        cw = 1'b0; cyc(1); state("cwtog_mid", 6, 1'b0, 1'b0);
        cw = 1'b1; cyc(1);
        cw = 1'b0; cyc(1);
        cw = 1'b1; cyc(1); state("cwtog_inc", 7, 1'b1, 1'b0);
        cw = 1'b1; cyc(3); state("cwlate_mid", 7, 1'b0, 1'b0);
        cw = 1'b0; cyc(1); state("cwlate_dec", 6, 1'b1, 1'b0);
        // paused single steps
        en = 1'b0; cw = 1'b1;
        cyc(2); state("pause_hold", 6, 1'b0, 1'b0);
        step = 1'b1; cyc(1); step = 1'b0; state("step1", 7, 1'b1, 1'b0);
        cyc(1); state("step_gap", 7, 1'b0, 1'b0);
        step = 1'b1; cyc(1); step = 1'b0; state("step2", 0, 1'b1, 1'b1);
        step = 1'b1; cyc(1); step = 1'b0; state("step3", 1, 1'b1, 1'b0);
        // step ignored while running; divider phase kept at 0 by the steps
        en = 1'b1; step = 1'b1; cyc(1); step = 1'b0;
        state("en_step", 1, 1'b0, 1'b0);
        cyc(2); state("resume_mid", 1, 1'b0, 1'b0);
        cyc(1); state("resume_adv", 2, 1'b1, 1'b0);
        // pause mid-interval at divider=2
        cyc(2); state("pre_pause", 2, 1'b0, 1'b0);
        en = 1'b0; cyc(10); state("mid_pause", 2, 1'b0, 1'b0);
        en = 1'b1; cyc(1); state("phase_1", 2, 1'b0, 1'b0);
        cyc(1); state("phase_2", 3, 1'b1, 1'b0);
        // asynchronous reset mid-run
        cyc(1);
        #2 reset = 1'b1;
        #1 state("reset_mid", 0, 1'b0, 1'b0);
        cyc(1); reset = 1'b0;
        cyc(2); state("post_reset", 0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
